// File: rtl/conversor_bcd_bin_2dig.sv
// Two-digit BCD to binary converter.
//
// A request samples data_BCD when start is high in idle, checks that both digits
// are decimal and that the value does not exceed MAX, then builds the binary value
// by repeated addition of ten (one cycle per tens digit). Rejected requests
// finish one cycle after capture with error set and data_bin left untouched.
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous reset, active low
//   data_BCD - two packed BCD digits {tens[7:4], units[3:0]}
//   start    - request strobe, honoured only while idle
//   busy     - high while checking or converting
//   done     - one-cycle completion pulse
//   error    - status of the last completed request (1 = rejected)
//   data_bin - last successfully decoded value
module conversor_bcd_bin_2dig #(
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_BCD,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [6:0] data_bin
);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StConv,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] bcd_q, bcd_d;
    logic [6:0] acc_q, acc_d;
    logic [3:0] tens_q, tens_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [6:0] data_bin_q, data_bin_d;

    logic [3:0] cap_tens;
    logic [3:0] cap_units;
    logic [7:0] cap_value;
    logic       req_valid;

    // Range check on the captured request; 8 bits hold up to 15*10+15.
    always_comb begin
        cap_tens  = bcd_q[7:4];
        cap_units = bcd_q[3:0];
        cap_value = ({4'b0000, cap_tens} * 8'd10) + {4'b0000, cap_units};
        req_valid = (cap_tens <= 4'd9) && (cap_units <= 4'd9) &&
                    ({24'd0, cap_value} <= MAX);
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        acc_d      = acc_q;
        tens_d     = tens_q;
        error_d    = error_q;
        data_bin_d = data_bin_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bcd_d   = data_BCD;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (req_valid) begin
                    acc_d   = {3'b000, cap_units};
                    tens_d  = cap_tens;
                    state_d = StConv;
                end else begin
                    error_d = 1'b1;
                    state_d = StDone;
                end
            end
            StConv: begin
                if (tens_q == 4'd0) begin
                    data_bin_d = acc_q;
                    error_d    = 1'b0;
                    state_d    = StDone;
                end else begin
                    acc_d  = acc_q + 7'd10;
                    tens_d = tens_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status flags are derived from the next state so they are registered
        // alongside it and line up with the state they describe.
        busy_d = (state_d == StCheck) || (state_d == StConv);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bcd_q      <= 8'd0;
            acc_q      <= 7'd0;
            tens_q     <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            data_bin_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            acc_q      <= acc_d;
            tens_q     <= tens_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            data_bin_q <= data_bin_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign data_bin = data_bin_q;

endmodule
